// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter.
// Requester ids index the internal grant vector.
package dmem_pkg;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, DMA and memory bus bundle around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid,
    output dma_gnt, dma_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid,
    input  dma_gnt, dma_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/starve_counter.sv
// Saturating wait counter; at_limit flags that the
// waiting requester must win the next conflict.
module starve_counter #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  assign at_limit = (cnt == LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority data-memory arbiter with a bounded
// DMA wait; stalls the core when it loses the port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  logic [1:0]        gnt;
  logic              dma_win;
  logic              at_limit;
  logic [CNT_W-1:0]  wait_cnt;
  logic              we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  always_comb begin
    dma_win = bus.dma_req & (~bus.core_req | at_limit);
    gnt = '0;
    gnt[REQ_DMA] = dma_win;
    gnt[REQ_CORE] = bus.core_req & ~dma_win;
  end

  always_comb begin
    we_mux = 1'b0;
    addr_mux = '0;
    wdata_mux = '0;
    unique case (1'b1)
      gnt[REQ_CORE]: begin
        we_mux = bus.core_we;
        addr_mux = bus.core_addr;
        wdata_mux = bus.core_wdata;
      end
      gnt[REQ_DMA]: begin
        we_mux = bus.dma_we;
        addr_mux = bus.dma_addr;
        wdata_mux = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  starve_counter #(
    .CNT_W(CNT_W),
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk(clk),
    .reset(reset),
    .clr(~bus.dma_req | gnt[REQ_DMA]),
    .inc(bus.dma_req & ~gnt[REQ_DMA]),
    .cnt(wait_cnt),
    .at_limit(at_limit)
  );

  // Grants stay live in reset, but nothing may reach memory.
  assign bus.mem_en = (|gnt) & reset;
  assign bus.mem_we = we_mux & reset;
  assign bus.mem_addr = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  assign bus.core_gnt = gnt[REQ_CORE];
  assign bus.dma_gnt = gnt[REQ_DMA];
  assign bus.core_stall = bus.core_req & ~gnt[REQ_CORE];
  assign bus.rdata = bus.mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      bus.core_rvalid <= gnt[REQ_CORE] & ~bus.core_we;
      bus.dma_rvalid <= gnt[REQ_DMA] & ~bus.dma_we;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: default build plus a DMA-priority
// (STARVE_LIMIT=0) build sharing the clock and reset.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  int checks;
  int failures;
  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(3)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0), .CNT_W(3)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_we)
        mem[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
      else
        bus_a.mem_rdata <= mem[bus_a.mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic core_drive(input logic r, input logic we,
                            input logic [31:0] a,
                            input logic [31:0] d);
    bus_a.core_req = r;
    bus_a.core_we = we;
    bus_a.core_addr = a;
    bus_a.core_wdata = d;
  endtask

  task automatic dma_drive(input logic r, input logic we,
                           input logic [31:0] a,
                           input logic [31:0] d);
    bus_a.dma_req = r;
    bus_a.dma_we = we;
    bus_a.dma_addr = a;
    bus_a.dma_wdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    bus_a.mem_rdata = 32'h0;
    bus_b.mem_rdata = 32'h0;
    bus_b.core_req = 1'b0;
    bus_b.core_we = 1'b0;
    bus_b.core_addr = 32'h0;
    bus_b.core_wdata = 32'h0;
    bus_b.dma_req = 1'b0;
    bus_b.dma_we = 1'b0;
    bus_b.dma_addr = 32'h0;
    bus_b.dma_wdata = 32'h0;
    core_drive(0, 0, 0, 0);
    dma_drive(0, 0, 0, 0);
    reset = 1'b0;

    // reset state, grant combinational but memory gated
    repeat (2) tick();
    core_drive(1, 0, 32'h10, 0);
    @(negedge clk);
    chk("rst_core_rvalid", bus_a.core_rvalid, 0);
    chk("rst_dma_rvalid", bus_a.dma_rvalid, 0);
    chk("rst_wait_cnt", u_dut.u_starve.cnt, 0);
    chk("rst_core_gnt", bus_a.core_gnt, 1);
    chk("rst_mem_en", bus_a.mem_en, 0);
    tick();
    core_drive(0, 0, 0, 0);
    reset = 1'b1;

    // core-only read
    tick();
    core_drive(1, 0, 32'h10, 0);
    @(negedge clk);
    chk("rd_core_gnt", bus_a.core_gnt, 1);
    chk("rd_mem_en", bus_a.mem_en, 1);
    chk("rd_mem_we", bus_a.mem_we, 0);
    chk("rd_mem_addr", bus_a.mem_addr, 32'h10);
    chk("rd_stall", bus_a.core_stall, 0);
    tick();
    core_drive(0, 0, 0, 0);
    @(negedge clk);
    chk("rd_core_rvalid", bus_a.core_rvalid, 1);
    chk("rd_rdata", bus_a.rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid", bus_a.dma_rvalid, 0);
    chk("idle_mem_en", bus_a.mem_en, 0);
    chk("idle_mem_addr", bus_a.mem_addr, 0);

    // sustained conflict: DMA wins one cycle in five
    tick();
    core_drive(1, 0, 32'h10, 0);
    dma_drive(1, 0, 32'h30, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cf_wait_cnt", u_dut.u_starve.cnt, 32'(i % 5));
      chk("cf_dma_gnt", bus_a.dma_gnt, (i % 5) == 4);
      chk("cf_core_gnt", bus_a.core_gnt, (i % 5) != 4);
      chk("cf_core_stall", bus_a.core_stall, (i % 5) == 4);
      chk("cf_mem_addr", bus_a.mem_addr,
          ((i % 5) == 4) ? 32'h30 : 32'h10);
    end
    tick();
    core_drive(0, 0, 0, 0);
    dma_drive(0, 0, 0, 0);

    // DMA write then core read of the same address
    tick();
    dma_drive(1, 1, 32'h20, 32'h12345678);
    @(negedge clk);
    chk("wr_dma_gnt", bus_a.dma_gnt, 1);
    chk("wr_mem_we", bus_a.mem_we, 1);
    chk("wr_mem_addr", bus_a.mem_addr, 32'h20);
    chk("wr_mem_wdata", bus_a.mem_wdata, 32'h12345678);
    tick();
    dma_drive(0, 0, 0, 0);
    core_drive(1, 0, 32'h20, 0);
    @(negedge clk);
    chk("wr_no_dma_rvalid", bus_a.dma_rvalid, 0);
    chk("wr_core_gnt", bus_a.core_gnt, 1);
    tick();
    core_drive(0, 0, 0, 0);
    @(negedge clk);
    chk("wr_core_rvalid", bus_a.core_rvalid, 1);
    chk("wr_rdata", bus_a.rdata, 32'h12345678);

    // DMA request withdrawn under contention
    tick();
    core_drive(1, 0, 32'h10, 0);
    dma_drive(1, 0, 32'h40, 0);
    @(negedge clk);
    chk("wd_cnt0", u_dut.u_starve.cnt, 0);
    chk("wd_dma_gnt0", bus_a.dma_gnt, 0);
    chk("wd_mem_en0", bus_a.mem_en, 1);
    @(negedge clk);
    chk("wd_cnt1", u_dut.u_starve.cnt, 1);
    tick();
    dma_drive(0, 0, 0, 0);
    @(negedge clk);
    chk("wd_cnt2", u_dut.u_starve.cnt, 2);
    chk("wd_dma_gnt2", bus_a.dma_gnt, 0);
    chk("wd_mem_en2", bus_a.mem_en, 1);
    @(negedge clk);
    chk("wd_cnt3", u_dut.u_starve.cnt, 0);
    tick();
    core_drive(0, 0, 0, 0);

    // asynchronous reset right after a granted read
    tick();
    core_drive(1, 0, 32'h10, 0);
    @(negedge clk);
    chk("ar_core_gnt", bus_a.core_gnt, 1);
    tick();
    chk("ar_rvalid_pre", bus_a.core_rvalid, 1);
    reset = 1'b0;
    #1;
    chk("ar_rvalid_drop", bus_a.core_rvalid, 0);
    chk("ar_wait_cnt", u_dut.u_starve.cnt, 0);
    chk("ar_mem_en", bus_a.mem_en, 0);
    chk("ar_gnt_live", bus_a.core_gnt, 1);
    @(negedge clk);
    chk("ar_rvalid_hold", bus_a.core_rvalid, 0);
    chk("ar_mem_en_hold", bus_a.mem_en, 0);
    reset = 1'b1;
    #1;
    chk("ar_resume_gnt", bus_a.core_gnt, 1);
    chk("ar_resume_en", bus_a.mem_en, 1);
    tick();
    core_drive(0, 0, 0, 0);
    @(negedge clk);
    chk("ar_resume_rvalid", bus_a.core_rvalid, 1);
    chk("ar_resume_rdata", bus_a.rdata, 32'hDEADBEEF);

    // DMA-priority build
    tick();
    bus_b.core_req = 1'b1;
    bus_b.core_addr = 32'h4;
    bus_b.dma_req = 1'b1;
    bus_b.dma_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dp_dma_gnt", bus_b.dma_gnt, 1);
      chk("dp_core_gnt", bus_b.core_gnt, 0);
      chk("dp_core_stall", bus_b.core_stall, 1);
      chk("dp_mem_addr", bus_b.mem_addr, 32'h8);
      chk("dp_wait_cnt", u_dut0.u_starve.cnt, 0);
    end
    tick();
    bus_b.dma_req = 1'b0;
    @(negedge clk);
    chk("dp_core_alone", bus_b.core_gnt, 1);
    chk("dp_dma_rvalid", bus_b.dma_rvalid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
